// File: rtl/uart_pkg.sv
// Shared UART types and constants for the RX and TX blocks.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;
    localparam int DEFAULT_BAUD_DIV = 868;
    localparam int UART_DATA_W      = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty; data read combinationally at rd_ptr.
// A write is visible to pop one cycle later; a push while full is dropped and flagged on drop_o.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_ok, pop_ok;

    // Gating on the registered flags means a pop never frees room for a same-cycle push.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;
    assign drop_o  = push_i && full_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers RX byte strobes in a FIFO and sends them back-to-back as 8N1 frames on uart_tx.
// Line falls two edges after the strobe when idle; no backpressure, bytes arriving while full are dropped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter  int DEPTH    = 16,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   ovf_clr,
    output logic                   uart_tx,
    output logic                   tx_busy,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   overflow
);
    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    tx_state_t              state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   ovf_q, ovf_d;
    logic                   pop, drop, tick;
    logic [UART_DATA_W-1:0] pop_dat;

    sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (in_valid),
        .push_dat_i (in_data),
        .pop_i      (pop),
        .pop_dat_o  (pop_dat),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .drop_o     (drop)
    );

    assign tick = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != IDLE) baud_d = tick ? '0 : baud_q + BW'(1);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = pop_dat;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued frames leave no idle gap.
                if (tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = pop_dat;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign uart_tx  = tx_q;
    assign tx_busy  = (state_q != IDLE);
    assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: small-parameter instance against a cycle-level queue/timing model,
// plus a default-parameter instance for frame timing.
module tb_uart_tx_fifo;
    localparam int B     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * B;
    localparam int LOGN  = 512;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, ovf_clr;
    logic [7:0] in_data;
    logic       uart_tx, tx_busy, fifo_full, fifo_empty, overflow;
    logic [2:0] fifo_count;

    logic       d_valid, d_clr;
    logic [7:0] d_data;
    logic       d_tx, d_busy, d_full, d_empty, d_ovf;
    logic [4:0] d_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_DIV(B), .DEPTH(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .ovf_clr(ovf_clr),
        .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_count(fifo_count), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .overflow(overflow)
    );

    uart_tx_fifo u_def (
        .clk(clk), .rst_n(rst_n), .in_data(d_data), .in_valid(d_valid), .ovf_clr(d_clr),
        .uart_tx(d_tx), .tx_busy(d_busy), .fifo_count(d_count), .fifo_full(d_full),
        .fifo_empty(d_empty), .overflow(d_ovf)
    );

    // Reference model: queued bytes plus the edge at which the current frame began.
    int         edge_n = 0;
    logic [7:0] mq[$];
    bit         m_busy = 0;
    int         f_start = 0;
    logic [7:0] f_byte = 8'h00;
    bit         m_ovf = 0;

    logic line_log [LOGN];
    logic busy_log [LOGN];
    int   log_n = 0;
    logic pat [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        bit pre_full;
        edge_n++;
        if (!rst_n) begin
            mq.delete();
            m_busy = 0;
            m_ovf  = 0;
            return;
        end
        pre_full = (mq.size() == D);
        if (m_busy && edge_n == f_start + FRAME) m_busy = 0;
        if (!m_busy && mq.size() > 0) begin
            f_byte  = mq.pop_front();
            f_start = edge_n;
            m_busy  = 1;
        end
        if (in_valid && pre_full)  m_ovf = 1;
        else if (ovf_clr)          m_ovf = 0;
        if (in_valid && !pre_full) mq.push_back(in_data);
    endtask

    function automatic logic exp_line();
        int k;
        if (!m_busy) return 1'b1;
        k = (edge_n - f_start) / B;
        if (k == 0) return 1'b0;
        if (k <= 8) return f_byte[k-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("line",  uart_tx,    exp_line());
        chk("busy",  tx_busy,    m_busy);
        chk("count", fifo_count, mq.size());
        chk("full",  fifo_full,  mq.size() == D);
        chk("empty", fifo_empty, mq.size() == 0);
        chk("ovf",   overflow,   m_ovf);
        if (log_n < LOGN) begin
            line_log[log_n] = uart_tx;
            busy_log[log_n] = tx_busy;
            log_n++;
        end
    endtask

    function automatic int first_low();
        for (int i = 0; i < log_n; i++) if (line_log[i] == 1'b0) return i;
        return 0;
    endfunction

    function automatic int busy_run(input int s);
        int n = 0;
        for (int i = s; i < log_n; i++) begin
            if (!busy_log[i]) break;
            n++;
        end
        return n;
    endfunction

    // Mid-bit sampling of frame f in the log, starting from the start-bit sample s.
    function automatic logic [7:0] decode(input int s, input int f);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = line_log[s + f*FRAME + (1+i)*B + B/2];
        return b;
    endfunction

    initial begin
        int         s, lows, rate, dn;
        logic [7:0] burst [3] = '{8'h55, 8'hAA, 8'h0F};
        int         tx_edges[$];
        int         busy_edges[$];
        logic       p_tx, p_busy;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; ovf_clr = 1'b0;
        d_valid = 1'b0; d_data = 8'h00; d_clr = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick();

        // Single byte 0x41
        log_n = 0;
        in_valid = 1'b1; in_data = 8'h41;
        tick();
        in_valid = 1'b0;
        repeat (44) tick();
        chk("single_pre_fall", line_log[0], 1);
        for (int j = 1; j <= 40; j++) chk("single_bit", line_log[j], pat[(j-1)/B]);
        chk("single_busy_last", busy_log[40], 1);
        chk("single_busy_end", busy_log[41], 0);
        chk("single_idle_line", line_log[41], 1);

        // Burst of three on consecutive cycles
        log_n = 0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_data = burst[j];
            tick();
        end
        in_valid = 1'b0;
        repeat (130) tick();
        s = first_low();
        chk("burst_fall", s, 1);
        chk("burst_contig", busy_run(s), 3*FRAME);
        for (int f = 0; f < 3; f++) chk("burst_byte", decode(s, f), burst[f]);
        chk("burst_empty", fifo_empty, 1);

        // Overflow, drop-with-clear, then plain clear
        log_n = 0;
        for (int j = 0; j < 6; j++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(j);
            tick();
            if (j == 4) chk("ovf_full", fifo_full, 1);
        end
        chk("ovf_set", overflow, 1);
        in_valid = 1'b1; in_data = 8'h16; ovf_clr = 1'b1;
        tick();
        chk("ovf_set_beats_clr", overflow, 1);
        in_valid = 1'b0;
        tick();
        chk("ovf_cleared", overflow, 0);
        ovf_clr = 1'b0;
        repeat (210) tick();
        s = first_low();
        chk("ovf_contig", busy_run(s), 5*FRAME);
        for (int f = 0; f < 5; f++) chk("ovf_byte", decode(s, f), 8'h10 + 8'(f));

        // Reset during data bit 3 of 0xC3 with two bytes queued
        in_valid = 1'b1; in_data = 8'hC3; tick();
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (m_busy && (edge_n - f_start) == 4*B + 1) break;
            tick();
        end
        chk("rst_reach_bit3", (edge_n - f_start), 4*B + 1);
        chk("pre_rst_count", fifo_count, 2);
        rst_n = 1'b0;
        tick();
        chk("midrst_tx", uart_tx, 1);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_busy", tx_busy, 0);
        rst_n = 1'b1;
        log_n = 0;
        repeat (60) tick();
        lows = 0;
        for (int i = 0; i < log_n; i++) if (line_log[i] == 1'b0) lows++;
        chk("no_frame_after_rst", lows, 0);

        // Randomised traffic with occasional clears and resets
        rate = 20;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) rate = $urandom_range(2, 80);
            in_valid = ($urandom_range(0, rate - 1) == 0);
            in_data  = 8'($urandom);
            ovf_clr  = ($urandom_range(0, 15) == 0);
            rst_n    = ($urandom_range(0, 699) != 0);
            tick();
        end
        in_valid = 1'b0; ovf_clr = 1'b0; rst_n = 1'b1;
        repeat (220) tick();
        chk("rand_drained", fifo_empty, 1);

        // Default parameters: one 0x7E frame
        d_valid = 1'b1; d_data = 8'h7E;
        p_tx = d_tx; p_busy = d_busy;
        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            if (i == 0) d_valid = 1'b0;
            if (d_tx !== p_tx) tx_edges.push_back(i);
            if (d_busy !== p_busy) busy_edges.push_back(i);
            p_tx = d_tx; p_busy = d_busy;
        end
        chk("def_tx_edges", tx_edges.size(), 4);
        chk("def_busy_edges", busy_edges.size(), 2);
        dn = tx_edges.size();
        if (dn == 4 && busy_edges.size() == 2) begin
            chk("def_fall", tx_edges[0], 1);
            chk("def_start_bit0", tx_edges[1] - tx_edges[0], 2*868);
            chk("def_bits1_6", tx_edges[2] - tx_edges[1], 6*868);
            chk("def_bit7", tx_edges[3] - tx_edges[2], 868);
            chk("def_busy_start", busy_edges[0], tx_edges[0]);
            chk("def_frame_len", busy_edges[1] - busy_edges[0], 8680);
            chk("def_stop_len", busy_edges[1] - tx_edges[3], 868);
        end else begin
            bad++;
            $error("FAIL def_edges_shape got=%0d/%0d exp=4/2", dn, busy_edges.size());
        end
        chk("def_line_idle", d_tx, 1);
        chk("def_empty", d_empty, 1);
        chk("def_count", d_count, 0);
        chk("def_full", d_full, 0);
        chk("def_ovf", d_ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
